// File: rtl/mem_bist_pkg.sv
// Shared types and widths for the memory built-in self-test engine.
package mem_bist_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned IDX_WIDTH  = ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Test parameters captured when Start is accepted.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [IDX_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] seed;
    logic                  invert;
  } test_cfg_t;

endpackage

// File: rtl/mem_bist_pattern.sv
// Pattern generator: (seed + idx) mod 2^16, optionally complemented.
module mem_bist_pattern
  import mem_bist_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  invert,
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic [DATA_WIDTH-1:0] pattern_c
);

  logic [DATA_WIDTH-1:0] sum;

  always_comb begin
    sum       = seed + DATA_WIDTH'(idx);
    pattern_c = invert ? ~sum : sum;
  end

endmodule

// File: rtl/mem_bist.sv
// Write-then-read-back memory self-test: writes a linear pattern over a
// wrapping address window, reads it back and counts mismatches.
module mem_bist
  import mem_bist_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [IDX_WIDTH-1:0]  count,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  invert,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_fail_address
);

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  state_e                state_q, state_d;
  test_cfg_t             cfg_q, cfg_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] ff_q, ff_d;
  logic                  pass_q, pass_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  last_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] pat_c;

  // One generator serves both paths: it looks at the next index, so the
  // write data and the expected read-back value are both registered.
  mem_bist_pattern u_pattern (
    .seed      (cfg_d.seed),
    .invert    (cfg_d.invert),
    .idx       (idx_d),
    .pattern_c (pat_c)
  );

  // Next-state, index and result bookkeeping.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    idx_d   = idx_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    last_c  = (idx_q == cfg_q.count - IDX_WIDTH'(1));

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cfg_d.base   = base_address;
          cfg_d.count  = count;
          cfg_d.seed   = seed;
          cfg_d.invert = invert;
          idx_d        = '0;
          err_d        = '0;
          ff_d         = '0;
          pass_d       = (count == '0);
          state_d      = (count == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          pass_d  = 1'b0;
        end else if (last_c) begin
          state_d = READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_WIDTH'(1);
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          pass_d  = 1'b0;
        end else begin
          if (mem_read_data != exp_q) begin
            err_d = (err_q == ERR_MAX) ? err_q : err_q + 16'd1;
            if (err_q == '0) ff_d = raddr_q;
          end
          if (last_c) begin
            state_d = DONE;
            idx_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side and status outputs, registered against the next state.
  always_comb begin
    addr_c  = cfg_d.base + ADDR_WIDTH'(idx_d);
    we_d    = (state_d == WRITE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    exp_d   = exp_q;
    raddr_d = cfg_d.base;
    if (state_d == WRITE) begin
      waddr_d = addr_c;
      wdata_d = pat_c;
      raddr_d = addr_c;
    end
    if (state_d == READ) begin
      raddr_d = addr_c;
      exp_d   = pat_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_write_enable   = we_q;
  assign mem_write_address  = waddr_q;
  assign mem_write_data     = wdata_q;
  assign mem_read_address   = raddr_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign error_count        = err_q;
  assign first_fail_address = ff_q;

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist with a behavioural memory and fault injection.
module tb_mem_bist;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] base_address;
  logic [15:0] count;
  logic [15:0] seed;
  logic        invert;
  logic        mem_write_enable;
  logic [15:0] mem_write_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_address;
  logic [15:0] mem_read_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] error_count;
  logic [15:0] first_fail_address;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned test_id = 0;

  logic [15:0] mem [0:65535];
  int unsigned tag [0:65535];
  logic        f0_en, f1_en;
  logic [15:0] f0_addr, f1_addr, f_mask;

  mem_bist dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .base_address       (base_address),
    .count              (count),
    .seed               (seed),
    .invert             (invert),
    .mem_write_enable   (mem_write_enable),
    .mem_write_address  (mem_write_address),
    .mem_write_data     (mem_write_data),
    .mem_read_address   (mem_read_address),
    .mem_read_data      (mem_read_data),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .error_count        (error_count),
    .first_fail_address (first_fail_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; each word remembers which test last wrote it.
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_write_address] <= mem_write_data;
      tag[mem_write_address] <= test_id;
    end
  end

  assign mem_read_data = mem[mem_read_address] ^
    (((f0_en && mem_read_address == f0_addr) || (f1_en && mem_read_address == f1_addr)) ? f_mask : 16'h0);

  function automatic logic [15:0] ref_pat(input logic [15:0] s, input logic inv, input int j);
    logic [15:0] v;
    v = s + 16'(j);
    return inv ? ~v : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic run_test(input logic [15:0] b, input logic [15:0] c, input logic [15:0] s,
                          input logic inv, input logic e0, input logic [15:0] a0,
                          input logic e1, input logic [15:0] a1, input logic [15:0] m,
                          input bit poke);
    int          done_at, dones, wes, exp_err, bad, best;
    logic        pass_at_done;
    logic [15:0] exp_ff, off, addr;
    logic [15:0] fa [2];
    logic        fe [2];
    test_id++;
    f0_en = e0; f0_addr = a0; f1_en = e1; f1_addr = a1; f_mask = m;
    base_address = b; count = c; seed = s; invert = inv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_address = 16'($urandom); count = 16'($urandom);
    seed = 16'($urandom); invert = 1'($urandom);
    done_at = -1; dones = 0; wes = 0; pass_at_done = 1'bx;
    for (int n = 0; n <= 2 * int'(c) + 2; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      start = (poke && c != 16'd0 && n == 1);
      if (done === 1'b1) begin
        dones++;
        if (done_at < 0) begin done_at = n; pass_at_done = pass; end
      end
      if (mem_write_enable === 1'b1) wes++;
    end
    start = 1'b0;
    // Reference: each faulted address inside the window is one mismatch.
    fa[0] = a0; fa[1] = a1; fe[0] = e0; fe[1] = e1 && !(e0 && a1 == a0);
    exp_err = 0; exp_ff = 16'h0; best = 65536;
    for (int k = 0; k < 2; k++) begin
      off = fa[k] - b;
      if (fe[k] && int'(off) < int'(c)) begin
        exp_err++;
        if (int'(off) < best) begin best = int'(off); exp_ff = fa[k]; end
      end
    end
    chk("done_latency", done_at, 2 * int'(c));
    chk("done_pulses", dones, 1);
    chk("write_cycles", wes, int'(c));
    chk("pass_at_done", 32'(pass_at_done), 32'(exp_err == 0));
    chk("error_count", 32'(error_count), exp_err);
    chk("first_fail", 32'(first_fail_address), 32'(exp_ff));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_raddr", 32'(mem_read_address), 32'(b));
    bad = 0;
    for (int j = 0; j < int'(c); j++) begin
      addr = b + 16'(j);
      if (tag[addr] != test_id || mem[addr] !== ref_pat(s, inv, j)) bad++;
    end
    chk("mem_contents", bad, 0);
    f0_en = 1'b0; f1_en = 1'b0;
  endtask

  initial begin
    logic [15:0] b, c, a0, a1;
    bit          e0, e1;
    int          dones;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_address = '0; count = '0; seed = '0; invert = 1'b0;
    f0_en = 1'b0; f1_en = 1'b0; f0_addr = '0; f1_addr = '0; f_mask = '0;
    #12;
    chk("rst_outputs", {busy, done, pass, mem_write_enable}, 0);
    chk("rst_addr", {mem_write_address, mem_read_address}, 0);
    chk("rst_status", {error_count, first_fail_address}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_test(16'h0000, 16'd4, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    b = 16'd2;
    chk("beef_word2", 32'(mem[b]), 32'h0000BEF1);
    run_test(16'h0000, 16'd4, 16'hBEEF, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    b = 16'd0;
    chk("inv_word0", 32'(mem[b]), 32'h00004110);
    b = 16'd3;
    chk("inv_word3", 32'(mem[b]), 32'h0000410D);
    run_test(16'h1234, 16'd0, 16'h5555, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    run_test(16'h0000, 16'd4, 16'hBEEF, 1'b0, 1'b1, 16'd2, 1'b0, 16'h0, 16'h0001, 1'b0);
    run_test(16'hFFFD, 16'd6, 16'h0F0F, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hFFFE, 16'h8000, 1'b1);

    for (int t = 0; t < 24; t++) begin
      b = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      c = 16'($urandom_range(0, 20));
      e0 = ($urandom_range(0, 1) == 1);
      e1 = ($urandom_range(0, 3) == 0);
      a0 = b + 16'($urandom_range(0, 24));
      a1 = b + 16'($urandom_range(0, 24));
      run_test(b, c, 16'($urandom), 1'($urandom), e0, a0, e1, a1,
               16'($urandom_range(1, 65535)), ($urandom_range(0, 1) == 1));
    end

    // Abort two cycles into the write phase.
    run_test(16'h0040, 16'd3, 16'hA5A5, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0);
    base_address = 16'h0100; count = 16'd10; seed = 16'h1234; invert = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_we0", 32'(mem_write_enable), 1);
    @(posedge clk); #1;
    chk("abort_we1", 32'(mem_write_enable), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(mem_write_enable), 0);
    chk("abort_pass", 32'(pass), 0);
    dones = int'(done);
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      dones += int'(done);
    end
    chk("abort_no_done", dones, 0);

    // Asynchronous reset while reading back.
    f0_en = 1'b1; f0_addr = 16'h0300; f_mask = 16'h00F0;
    base_address = 16'h0300; count = 16'd5; seed = 16'h7777; invert = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 6; n++) begin @(posedge clk); #1; end
    chk("pre_reset_err", 32'(error_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {busy, done, pass, mem_write_enable}, 0);
    chk("midrst_addr", {mem_write_address, mem_read_address}, 0);
    chk("midrst_data", {mem_write_data, 16'h0}, 0);
    chk("midrst_status", {error_count, first_fail_address}, 0);
    f0_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      dones += int'(done);
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
